// File: rtl/adc_pkg.sv
// Shared state encoding and default framing constants for the LTC2315 sequencer.
package adc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_ACQ  = 2'd2
  } adc_seq_state_t;

  localparam int unsigned ADC_CONV_LEN  = 14;
  localparam int unsigned ADC_FRAME_LEN = 18;
  localparam int unsigned ADC_DATA_W    = 12;
  localparam int unsigned ADC_CNT_W     = 16;

endpackage

// File: rtl/adc_sck_gen.sv
// Serial clock divider: sck low for the first CLK_DIV cycles of each period, high
// for the rest; strobes mark the clk edges that will raise / lower sck.
module adc_sck_gen
  import adc_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned FRAME_LEN = ADC_FRAME_LEN,
  parameter int unsigned PER_W     = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  output logic             sck_o,
  output logic             rise_stb_c_o,
  output logic             fall_stb_c_o,
  output logic [PER_W-1:0] period_o
);

  localparam int unsigned CNT_W = $clog2(2 * CLK_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PER_W-1:0] period_q, period_d;
  logic             sck_q, sck_d;

  assign rise_stb_c_o = en_i && (cnt_q == CNT_W'(CLK_DIV - 1));
  assign fall_stb_c_o = en_i && (cnt_q == CNT_W'(2 * CLK_DIV - 1));

  // Period index wraps per frame so continuous frames need no reload.
  always_comb begin
    cnt_d    = '0;
    period_d = '0;
    sck_d    = 1'b0;
    if (en_i) begin
      cnt_d    = fall_stb_c_o ? '0 : cnt_q + 1'b1;
      period_d = period_q;
      if (fall_stb_c_o) begin
        period_d = (period_q == PER_W'(FRAME_LEN - 1)) ? '0 : period_q + 1'b1;
      end
      sck_d = (cnt_d >= CNT_W'(CLK_DIV));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      period_q <= '0;
      sck_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      period_q <= period_d;
      sck_q    <= sck_d;
    end
  end

  assign sck_o    = sck_q;
  assign period_o = period_q;

endmodule

// File: rtl/adc_sequencer.sv
// LTC2315 acquisition sequencer: frames conversions, deserialises each sample and
// presents it on a valid/ready stream in single-shot, burst or continuous mode.
module adc_sequencer
  import adc_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned FRAME_LEN = ADC_FRAME_LEN,
  parameter int unsigned CONV_LEN  = ADC_CONV_LEN,
  parameter int unsigned DATA_W    = ADC_DATA_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 stop_i,
  input  logic [ADC_CNT_W-1:0] burst_len_i,
  input  logic                 miso_i,
  output logic                 sck_o,
  output logic                 cs_n_o,
  output logic [DATA_W-1:0]    data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 busy_o,
  output logic                 overrun_o,
  output logic [ADC_CNT_W-1:0] frame_cnt_o
);

  localparam int unsigned PER_W = $clog2(FRAME_LEN);

  adc_seq_state_t       state_q, state_d;
  logic                 cs_n_q, cs_n_d, busy_q, busy_d;
  logic [DATA_W-1:0]    shreg_q, shreg_d, data_q, data_d;
  logic                 valid_q, valid_d, overrun_q, overrun_d;
  logic                 sample_q, sample_d, stop_pend_q, stop_pend_d;
  logic [ADC_CNT_W-1:0] len_q, len_d, frame_cnt_q, frame_cnt_d, frame_cnt_inc;
  logic                 sck_en, rise_stb, fall_stb;
  logic [PER_W-1:0]     period;
  logic                 start_acc, conv_end, frame_end, burst_done;

  assign sck_en = (state_q != ST_IDLE);

  adc_sck_gen #(
    .CLK_DIV  (CLK_DIV),
    .FRAME_LEN(FRAME_LEN),
    .PER_W    (PER_W)
  ) u_sck_gen (
    .clk         (clk),
    .rst         (rst),
    .en_i        (sck_en),
    .sck_o       (sck_o),
    .rise_stb_c_o(rise_stb),
    .fall_stb_c_o(fall_stb),
    .period_o    (period)
  );

  assign start_acc     = (state_q == ST_IDLE) && start_i;
  assign conv_end      = (state_q == ST_CONV) && fall_stb && (period == PER_W'(CONV_LEN - 1));
  assign frame_end     = (state_q == ST_ACQ) && fall_stb && (period == PER_W'(FRAME_LEN - 1));
  assign frame_cnt_inc = (frame_cnt_q == '1) ? frame_cnt_q : frame_cnt_q + 1'b1;
  assign burst_done    = (len_q != '0) && (frame_cnt_inc == len_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // A stop sampled on the frame-end cycle itself still ends the run.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_i) state_d = ST_CONV;
      ST_CONV: if (conv_end) state_d = ST_ACQ;
      ST_ACQ: begin
        if (frame_end) begin
          state_d = (stop_pend_q || stop_i || burst_done) ? ST_IDLE : ST_CONV;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cs_n_d = 1'b1;
    busy_d = 1'b0;
    if (state_d == ST_CONV) cs_n_d = 1'b0;
    if (state_d != ST_IDLE) busy_d = 1'b1;
  end

  // Last shift lands one cycle before the sample is offered downstream.
  always_comb begin
    shreg_d = shreg_q;
    if ((state_q == ST_CONV) && rise_stb) shreg_d = {shreg_q[DATA_W-2:0], miso_i};
    sample_d = (state_q == ST_CONV) && rise_stb && (period == PER_W'(CONV_LEN - 1));

    len_d       = start_acc ? burst_len_i : len_q;
    frame_cnt_d = frame_cnt_q;
    if (start_acc)      frame_cnt_d = '0;
    else if (frame_end) frame_cnt_d = frame_cnt_inc;

    stop_pend_d = stop_pend_q;
    if ((state_q != ST_IDLE) && stop_i) stop_pend_d = 1'b1;
    if (state_d == ST_IDLE)             stop_pend_d = 1'b0;

    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (valid_q && ready_i) valid_d = 1'b0;
    if (sample_q) begin
      if (valid_q && !ready_i) begin
        overrun_d = 1'b1;
      end else begin
        data_d  = shreg_q;
        valid_d = 1'b1;
      end
    end
    if (start_acc) overrun_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_n_q      <= 1'b1;
      busy_q      <= 1'b0;
      shreg_q     <= '0;
      sample_q    <= 1'b0;
      len_q       <= '0;
      frame_cnt_q <= '0;
      stop_pend_q <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      cs_n_q      <= cs_n_d;
      busy_q      <= busy_d;
      shreg_q     <= shreg_d;
      sample_q    <= sample_d;
      len_q       <= len_d;
      frame_cnt_q <= frame_cnt_d;
      stop_pend_q <= stop_pend_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign cs_n_o      = cs_n_q;
  assign busy_o      = busy_q;
  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign overrun_o   = overrun_q;
  assign frame_cnt_o = frame_cnt_q;

endmodule

// File: tb/tb_adc_sequencer.sv
// Directed bench for adc_sequencer with a behavioural LTC2315 serial model.
module tb_adc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i, stop_i, miso_i, ready_i;
  logic [15:0] burst_len_i;
  logic        sck_o, cs_n_o, valid_o, busy_o, overrun_o;
  logic [11:0] data_o;
  logic [15:0] frame_cnt_o;

  adc_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .stop_i     (stop_i),
    .burst_len_i(burst_len_i),
    .miso_i     (miso_i),
    .sck_o      (sck_o),
    .cs_n_o     (cs_n_o),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .busy_o     (busy_o),
    .overrun_o  (overrun_o),
    .frame_cnt_o(frame_cnt_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // ADC model: one word per frame, period p (2..13) carries bit 13-p, MSB first.
  logic [11:0] words [4];
  logic [11:0] cur_word = '0;
  int widx = 0;
  int rise_n = 0;
  int last_rise_n = 0;

  function automatic logic bit_for(input int p, input logic [11:0] w);
    if (p >= 2 && p <= 13) return w[13-p];
    return 1'b0;
  endfunction

  initial miso_i = 1'b0;
  always @(negedge cs_n_o or posedge sck_o) begin
    if (sck_o == 1'b0) begin
      rise_n   = 0;
      cur_word = (widx < 4) ? words[widx] : 12'h000;
      widx++;
    end else begin
      rise_n++;
    end
    miso_i = bit_for(rise_n, cur_word);
  end

  always @(posedge cs_n_o) last_rise_n = rise_n;

  // Output log: accepted samples, valid activity, cs_n and busy timing.
  logic [11:0] got_q[$];
  int got_cyc[$];
  int valid_cnt = 0;
  int cs_fall_cyc = 0, cs_low_len = 0, busy_fall_cyc = 0;
  logic prev_cs = 1'b1, prev_busy = 1'b0;

  always @(negedge clk) begin
    if (valid_o && ready_i) begin
      got_q.push_back(data_o);
      got_cyc.push_back(cyc);
    end
    if (valid_o === 1'b1) valid_cnt++;
    if (prev_cs && !cs_n_o) cs_fall_cyc = cyc;
    if (!prev_cs && cs_n_o) cs_low_len = cyc - cs_fall_cyc;
    if (prev_busy && !busy_o) busy_fall_cyc = cyc;
    prev_cs   = cs_n_o;
    prev_busy = busy_o;
  end

  function automatic logic [11:0] got_at(input int i);
    if (i < got_q.size()) return got_q[i];
    return 12'bx;
  endfunction

  function automatic int cyc_at(input int i);
    if (i < got_cyc.size()) return got_cyc[i];
    return -1;
  endfunction

  int start_cyc = 0;

  task automatic set_words(input logic [11:0] w0, w1, w2, w3);
    @(posedge clk);
    #1;
    words[0] = w0; words[1] = w1; words[2] = w2; words[3] = w3;
    widx = 0;
    got_q.delete();
    got_cyc.delete();
    valid_cnt = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    start_cyc = cyc;
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; stop_i = 1'b0; burst_len_i = '0; ready_i = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ctrl", {27'd0, sck_o, cs_n_o, valid_o, busy_o, overrun_o}, 32'b01000);
    chk("rst_data", data_o, 0);
    chk("rst_fcnt", frame_cnt_o, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Single shot
    set_words(12'hA5C, 12'h000, 12'h000, 12'h000);
    burst_len_i = 16'd1;
    pulse_start();
    chk("s1_cs_fall", cs_n_o, 0);
    chk("s1_busy", busy_o, 1);
    repeat (80) @(negedge clk);
    chk("s1_count", got_q.size(), 1);
    chk("s1_data", got_at(0), 12'hA5C);
    chk("s1_valid_cyc", cyc_at(0) - start_cyc, 55);
    chk("s1_cs_len", cs_low_len, 56);
    chk("s1_sck_periods", last_rise_n, 14);
    chk("s1_fcnt", frame_cnt_o, 1);
    chk("s1_busy_fall", busy_fall_cyc - start_cyc, 72);
    chk("s1_idle", {29'd0, busy_o, cs_n_o, sck_o}, 32'b010);

    // Burst of four
    set_words(12'h001, 12'h800, 12'hFFF, 12'h7FE);
    burst_len_i = 16'd4;
    pulse_start();
    repeat (300) @(negedge clk);
    chk("b4_count", got_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("b4_data%0d", i), got_at(i), words[i]);
      chk($sformatf("b4_cyc%0d", i), cyc_at(i) - start_cyc, 55 + 72 * i);
    end
    chk("b4_fcnt", frame_cnt_o, 4);
    chk("b4_busy_fall", busy_fall_cyc - start_cyc, 288);

    // Backpressure in continuous mode
    set_words(12'h5A5, 12'h3C3, 12'h0C3, 12'h000);
    burst_len_i = 16'd0;
    ready_i = 1'b0;
    pulse_start();
    repeat (210) @(negedge clk);
    chk("bp_data_kept", data_o, 12'h5A5);
    chk("bp_valid", valid_o, 1);
    chk("bp_overrun", overrun_o, 1);
    chk("bp_fcnt", frame_cnt_o, 2);
    @(posedge clk);
    #1 ready_i = 1'b1; stop_i = 1'b1;
    @(posedge clk);
    #1 stop_i = 1'b0;
    repeat (20) @(negedge clk);
    chk("bp_drain_count", got_q.size(), 1);
    chk("bp_drain_data", got_at(0), 12'h5A5);
    chk("bp_idle", busy_o, 0);
    chk("bp_fcnt_end", frame_cnt_o, 3);
    chk("bp_sticky", overrun_o, 1);
    set_words(12'h0F0, 12'h000, 12'h000, 12'h000);
    burst_len_i = 16'd1;
    pulse_start();
    chk("bp_ovr_clear", overrun_o, 0);
    repeat (80) @(negedge clk);
    chk("bp_restart_data", got_at(0), 12'h0F0);

    // Stop mid-frame (cycle 20 of frame 2)
    set_words(12'h123, 12'h456, 12'h789, 12'h000);
    burst_len_i = 16'd0;
    pulse_start();
    repeat (91) @(negedge clk);
    stop_i = 1'b1;
    @(negedge clk);
    stop_i = 1'b0;
    repeat (100) @(negedge clk);
    chk("stop_count", got_q.size(), 2);
    chk("stop_data0", got_at(0), 12'h123);
    chk("stop_data1", got_at(1), 12'h456);
    chk("stop_cyc1", cyc_at(1) - start_cyc, 127);
    chk("stop_cs_len", cs_low_len, 56);
    chk("stop_fcnt", frame_cnt_o, 2);
    chk("stop_busy_fall", busy_fall_cyc - start_cyc, 144);

    // Asynchronous reset mid-frame
    set_words(12'h777, 12'h000, 12'h000, 12'h000);
    burst_len_i = 16'd0;
    pulse_start();
    repeat (30) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("ar_ctrl", {27'd0, sck_o, cs_n_o, valid_o, busy_o, overrun_o}, 32'b01000);
    chk("ar_data", data_o, 0);
    chk("ar_fcnt", frame_cnt_o, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    chk("ar_no_valid", valid_cnt, 0);
    chk("ar_stays_idle", {30'd0, busy_o, cs_n_o}, 32'b01);
    set_words(12'h3C3, 12'h000, 12'h000, 12'h000);
    burst_len_i = 16'd1;
    pulse_start();
    repeat (80) @(negedge clk);
    chk("ar_restart_data", got_at(0), 12'h3C3);
    chk("ar_restart_cyc", cyc_at(0) - start_cyc, 55);
    chk("ar_restart_fcnt", frame_cnt_o, 1);

    // start and stop in the same idle cycle
    set_words(12'h111, 12'h222, 12'h000, 12'h000);
    burst_len_i = 16'd2;
    @(negedge clk);
    start_i = 1'b1; stop_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; stop_i = 1'b0;
    start_cyc = cyc;
    repeat (160) @(negedge clk);
    chk("ss_count", got_q.size(), 2);
    chk("ss_data1", got_at(1), 12'h222);
    chk("ss_fcnt", frame_cnt_o, 2);
    chk("ss_busy_fall", busy_fall_cyc - start_cyc, 144);

    // start while busy is ignored
    set_words(12'hAAA, 12'hBBB, 12'hCCC, 12'h000);
    burst_len_i = 16'd3;
    pulse_start();
    repeat (99) @(negedge clk);
    burst_len_i = 16'd1;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (50) @(negedge clk);
    chk("sb_fcnt_mid", frame_cnt_o, 2);
    repeat (80) @(negedge clk);
    chk("sb_fcnt_end", frame_cnt_o, 3);
    chk("sb_busy_fall", busy_fall_cyc - start_cyc, 216);
    chk("sb_data2", got_at(2), 12'hCCC);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/adc_sequencer.md
# adc_sequencer

Controller that drives the LTC2315 serial ADC from the system clock domain. It generates `sck_o` and `cs_n_o`, frames each conversion, and deserialises the 12-bit result. Samples go out on a valid/ready stream in single-shot, burst or continuous mode. It sits between the register/control block and the sample-processing pipeline, and replaces free-running ADC clocking with software-controlled acquisition.

## Interface

Parameters:
- `CLK_DIV`, default 2: `clk` cycles per `sck_o` half-period; legal range ≥1.
- `FRAME_LEN`, default 18: `sck_o` periods per sample frame; must exceed `CONV_LEN`.
- `CONV_LEN`, default 14: `sck_o` periods with `cs_n_o` low per frame; legal range ≥13.
- `DATA_W`, default 12: sample width.

Ports:
- `clk` in 1: system clock; all logic runs on its rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `start_i` in 1: one-cycle pulse that starts acquisition; ignored while `busy_o`=1.
- `stop_i` in 1: one-cycle pulse that requests a stop after the current frame completes.
- `burst_len_i` in 16: number of frames to run; 0 = continuous. Latched on `start_i`.
- `miso_i` in 1: ADC serial data.
- `sck_o` out 1: ADC serial clock.
- `cs_n_o` out 1: ADC chip select / convert, active low.
- `data_o` out `DATA_W`: sample, MSB = first captured bit.
- `valid_o` out 1: `data_o` holds an unconsumed sample.
- `ready_i` in 1: downstream accepts the sample when `valid_o`=1 and `ready_i`=1.
- `busy_o` out 1: high from the cycle after an accepted `start_i` until return to IDLE.
- `overrun_o` out 1: sticky flag; cleared on an accepted `start_i`.
- `frame_cnt_o` out 16: frames completed since the last start.

## Operation

- States are IDLE, CONV and ACQ. Each sck period is 2×`CLK_DIV` clk cycles: `sck_o` is low for the first half and high for the second.
- IDLE: `sck_o`=0 and `cs_n_o`=1. An accepted `start_i` latches `burst_len_i`, clears `frame_cnt_o` and `overrun_o`, zeroes the period counter, and moves to CONV.
- CONV: `cs_n_o`=0. On every clk edge that drives `sck_o` 0→1, `miso_i` is shifted into a `DATA_W`-bit shift register, MSB first.
  - On the falling half of period index `CONV_LEN-1`, the low `DATA_W` bits of the register become the sample. The register therefore captures periods `CONV_LEN-DATA_W` … `CONV_LEN-1`.
  - The state then moves to ACQ.
- ACQ: `cs_n_o`=1 and `sck_o` keeps toggling for `FRAME_LEN-CONV_LEN` periods. At the end of the frame, `frame_cnt_o` increments, saturating at 0xFFFF.
- End-of-frame decision:
  - Return to IDLE if a stop is pending, or if `burst_len_i`≠0 and `frame_cnt_o` (post-increment) equals the latched length.
  - Otherwise go to CONV for the next frame.
- Output register:
  - A new sample loads `data_o` and sets `valid_o`.
  - `valid_o` clears on a handshake.
  - If a new sample arrives while `valid_o`=1 and `ready_i`=0, the new sample is dropped, `data_o` is unchanged and `overrun_o` is set.
  - If a handshake and a new sample occur in the same cycle, the new sample loads and `valid_o` stays 1.
- Stop handling:
  - `stop_i` in IDLE is ignored.
  - During CONV or ACQ it sets a pending-stop flag; the frame always completes and `cs_n_o` is never raised early.
  - `start_i` and `stop_i` in the same IDLE cycle: start wins and the stop is ignored.
- Reset values: `sck_o`=0, `cs_n_o`=1, `data_o`=0, `valid_o`=0, `busy_o`=0, `overrun_o`=0, `frame_cnt_o`=0, state IDLE.
- Reset mid-frame aborts immediately and the partial sample is discarded.

## Timing

- `cs_n_o` falls on the clk edge after an accepted `start_i`.
- The first `sck_o` rise comes `CLK_DIV` cycles after `cs_n_o` falls.
- `valid_o` rises `(CONV_LEN-1)×2×CLK_DIV + CLK_DIV + 1` cycles after `start_i`; that is 55 cycles at the defaults.
- Frame period is `FRAME_LEN×2×CLK_DIV` clk cycles; 72 at the defaults.
- Back-to-back frames in continuous mode have no idle gap.
- `busy_o` falls on the same edge that returns the state machine to IDLE.

## Structure

- Package `adc_pkg`:
  - state enum `adc_seq_state_t`
  - default constants `ADC_CONV_LEN`=14, `ADC_FRAME_LEN`=18, `ADC_DATA_W`=12
- Sub-module `adc_sck_gen`: divider that emits `sck_o` plus one-cycle `rise_stb`/`fall_stb` strobes and the period count. It runs only when enabled and is held low in IDLE.
- The top level holds the FSM, shift register, output register and counters.

## Test plan

- Single shot: `burst_len_i`=1, ADC model returns 0xA5C, `ready_i`=1.
  - Expect exactly one `valid_o` pulse with `data_o`=0xA5C at cycle 55, and 14 sck periods with `cs_n_o`=0.
  - Expect `frame_cnt_o`=1, and `busy_o`=0 after 72 cycles.
- Burst: `burst_len_i`=4 with samples 0x001, 0x800, 0xFFF, 0x7FE.
  - Expect the four values in order, 72 cycles apart, then IDLE with `frame_cnt_o`=4.
- Backpressure: continuous mode with `ready_i`=0 held for 3 frames.
  - Expect `data_o` to keep the first sample and `overrun_o`=1.
  - After `ready_i`=1 and a new `start_i`, expect `overrun_o`=0.
- Stop mid-frame: `stop_i` at cycle 20 of frame 2 in continuous mode.
  - Expect frame 2 to complete with `cs_n_o` timing unaltered and sample delivered, then IDLE with `frame_cnt_o`=2.
- Async reset at cycle 30 of a frame: expect all outputs at their reset values immediately, `valid_o` never asserted, and a clean restart on the next `start_i`.
- Simultaneous events:
  - `start_i` and `stop_i` in the same IDLE cycle: expect the burst to run.
  - `start_i` while busy: expect it to be ignored and `frame_cnt_o` not reset.
